// File: rtl/booth8_digit_encoder.sv
// Radix-8 Booth digit encoder for a 13-bit multiplier operand.
// It emits five signed digits, most significant first, as sign/magnitude codes
// on a valid/ready stream. It also holds the registered multiplicand multiples
// 2a..5a for the downstream shift-and-add accumulator.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both high.
// A producer holds valid and its payload stable until that edge. Both ready signals
// are free to change on any cycle.
module booth8_digit_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [12:0] b,
    input  logic [12:0] a,
    output logic [3:0]  s,
    output logic        s_valid,
    input  logic        s_ready,
    output logic        s_first,
    output logic        s_last,
    output logic [12:0] a_mul_2,
    output logic [12:0] a_mul_3,
    output logic [12:0] a_mul_4,
    output logic [12:0] a_mul_5,
    output logic        dbg_emit
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] x_q, x_d;
    logic [2:0]  k_q, k_d;
    logic [3:0]  s_q, s_d;
    logic        s_valid_q, s_valid_d;
    logic        in_ready_q, in_ready_d;
    logic        s_first_q, s_first_d;
    logic        s_last_q, s_last_d;
    logic [12:0] m2_q, m2_d, m3_q, m3_d, m4_q, m4_d, m5_q, m5_d;

    // Window {b[3k+2], b[3k+1], b[3k], b[3k-1]} mapped to a sign/magnitude code.
    // A window of all ones is a zero digit and is encoded as a plain zero.
    function automatic logic [3:0] encode_digit(input logic [15:0] x, input logic [2:0] k);
        logic [3:0] w;
        logic [2:0] m;
        logic [3:0] code;
        case (k)
            3'd0:    w = x[3:0];
            3'd1:    w = x[6:3];
            3'd2:    w = x[9:6];
            3'd3:    w = x[12:9];
            default: w = x[15:12];
        endcase
        m = {1'b0, w[2], 1'b0} + {2'b00, w[1]} + {2'b00, w[0]};
        if (!w[3])
            code = {1'b0, m};
        else if (m == 3'd4)
            code = 4'b0000;
        else
            code = {1'b1, 3'd4 - m};
        return code;
    endfunction

    // Next-state and next-output logic. Outputs are registered from the next state.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        k_d        = k_q;
        m2_d       = m2_q;
        m3_d       = m3_q;
        m4_d       = m4_q;
        m5_d       = m5_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = EMIT;
                    x_d     = {2'b00, b, 1'b0};
                    k_d     = 3'd4;
                    m2_d    = {a[11:0], 1'b0};
                    m4_d    = {a[10:0], 2'b00};
                    m3_d    = a + {a[11:0], 1'b0};
                    m5_d    = a + {a[10:0], 2'b00};
                end
            end
            default: begin
                if (s_ready) begin
                    if (k_q != 3'd0)
                        k_d = k_q - 3'd1;
                    else
                        state_d = IDLE;
                end
            end
        endcase
        s_valid_d  = (state_d == EMIT);
        in_ready_d = (state_d == IDLE);
        s_d        = (state_d == EMIT) ? encode_digit(x_d, k_d) : 4'b0000;
        s_first_d  = (state_d == EMIT) && (k_d == 3'd4);
        s_last_d   = (state_d == EMIT) && (k_d == 3'd0);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            x_q        <= 16'd0;
            k_q        <= 3'd0;
            s_q        <= 4'd0;
            s_valid_q  <= 1'b0;
            in_ready_q <= 1'b1;
            s_first_q  <= 1'b0;
            s_last_q   <= 1'b0;
            m2_q       <= 13'd0;
            m3_q       <= 13'd0;
            m4_q       <= 13'd0;
            m5_q       <= 13'd0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            k_q        <= k_d;
            s_q        <= s_d;
            s_valid_q  <= s_valid_d;
            in_ready_q <= in_ready_d;
            s_first_q  <= s_first_d;
            s_last_q   <= s_last_d;
            m2_q       <= m2_d;
            m3_q       <= m3_d;
            m4_q       <= m4_d;
            m5_q       <= m5_d;
        end
    end

    assign in_ready = in_ready_q;
    assign s        = s_q;
    assign s_valid  = s_valid_q;
    assign s_first  = s_first_q;
    assign s_last   = s_last_q;
    assign a_mul_2  = m2_q;
    assign a_mul_3  = m3_q;
    assign a_mul_4  = m4_q;
    assign a_mul_5  = m5_q;
    assign dbg_emit = (state_q == EMIT);

endmodule

// File: doc/booth8_digit_encoder.md
# booth8_digit_encoder

Sequential radix-8 Booth recoder that produces the signed-digit stream consumed by the schoolbook multiplier's shift-and-add datapath. It accepts one 13-bit multiplier operand `b` and one 13-bit multiplicand `a` per transaction. It emits the five signed digits of `b`, most significant first, as 4-bit sign/magnitude codes over a valid/ready handshake. It also holds registered multiples 2a..5a, so the downstream accumulator can form Ri ± s·a each cycle.

## Interface

Parameters: none (widths fixed: operand 13 bits, 5 digits).

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand pair present.
- `in_ready` out 1: block idle and able to accept.
- `b` in 13: multiplier operand, unsigned.
- `a` in 13: multiplicand, unsigned.
- `s` out 4: digit code; `s[3]` = negative, `s[2:0]` = magnitude 0..4.
- `s_valid` out 1: `s` valid.
- `s_ready` in 1: consumer takes digit.
- `s_first` out 1: current digit is index 4 (MSB).
- `s_last` out 1: current digit is index 0 (LSB).
- `a_mul_2`, `a_mul_3`, `a_mul_4`, `a_mul_5` out 13 each: 2a, 3a, 4a, 5a, each modulo 2^13.

## Operation

- **States:**
  - IDLE: `in_ready`=1, `s_valid`=0.
  - EMIT: `in_ready`=0, `s_valid`=1.
- **IDLE→EMIT** on `in_valid && in_ready`:
  - Capture `{2'b00, b, 1'b0}` into a 16-bit register `x`, where `x[0]` is the Booth pad b[-1].
  - Load digit index `k` = 4.
  - Register `a` and all four multiples.
- **Digit k** uses `w = x[3k+3 : 3k]`, i.e. {b[3k+2], b[3k+1], b[3k], b[3k-1]}:
  - Value: d = −4·w[3] + 2·w[2] + w[1] + w[0], range −4..+4. Digit 4 is always 0..2.
  - Encoding: d ≥ 0 gives `s = {1'b0, d}`; d < 0 gives `s = {1'b1, −d}`.
  - Zero is always 4'b0000; a negative zero is never emitted.
- **In EMIT:**
  - On `s_valid && s_ready` with k > 0: decrement k.
  - On the handshake with k = 0: return to IDLE.
  - `s_first` = (k == 4); `s_last` = (k == 0); both are 0 in IDLE.
- **Identity:** b = Σ d_k·8^k. The consumer computes Ri ← 8·Ri ± |d_k|·a (Horner) in the order emitted.
- **Multiples:**
  - 2a = {a[11:0],0}; 4a = {a[10:0],00}; 3a = a + 2a; 5a = a + 4a, all truncated to 13 bits.
  - They are held constant from the accept until the next accept.
  - `a_mul_5` is always driven even though this encoder never emits magnitude 5.
- **No overlap:** a new operand is not accepted in the cycle the last digit is taken.

## Timing

- **Reset values:**
  - State IDLE, `in_ready`=1 (from the cycle after reset deasserts).
  - `s_valid`=0, `s`=0, `s_first`=0, `s_last`=0.
  - All `a_mul_*`=0, `x`=0, `k`=0.
- **Latency:** accept in cycle N gives digit 4 valid in cycle N+1.
- **Throughput:** with `s_ready` held high, digits appear in cycles N+1..N+5, `in_ready` is high in N+6, and the next accept is no earlier than N+6 (6 cycles per operand).
- **Backpressure:**
  - While `s_valid && !s_ready`, `s`, `s_first`, `s_last`, k and all `a_mul_*` hold stable.
  - `s_valid` never drops before the handshake.
- **Input side:**
  - `in_valid` while `in_ready`=0 is ignored; nothing is captured.
  - `b` and `a` are sampled only on the accept edge.
- **Reset mid-EMIT:**
  - The transaction is aborted and remaining digits are discarded.
  - In the next cycle `s_valid`=0, `in_ready`=1, and `a_mul_*`=0.
- **Reset with `in_valid` high:** no capture; reset wins.

## Test plan

1. Reset, then b=1, a=100, `s_ready`=1 → `s`=0000,0000,0000,0000,0001 in cycles N+1..N+5. `s_first` is high on the first code only, `s_last` on the fifth only. `a_mul_2`=200, `a_mul_3`=300, `a_mul_4`=400, `a_mul_5`=500.
2. b=8191 → `s`=0010,0000,0000,0000,1001 (+2,0,0,0,−1). b=7 → 0000,0000,0000,0001,1001. b=4 → 0000,0000,0000,0001,1100.
3. a=3000 → `a_mul_2`=6000, `a_mul_3`=808, `a_mul_4`=3808, `a_mul_5`=6808 (mod 8192 wrap).
4. Backpressure, b=8191: `s_ready` low for 3 cycles after digit 4 is presented, and `in_valid` pulsed with b=5 during EMIT → digit 4 code 0010 and `s_first` held for 3 cycles. The full sequence then completes unchanged, and b=5 is never captured.
5. Reset asserted after 2 digit handshakes → next cycle `s_valid`=0, `in_ready`=1, `a_mul_*`=0. A new b=1 is then processed correctly from digit 4.
6. 1000 random (a, b) pairs with random `s_ready` → Horner reconstruction Σ d_k·8^k equals b exactly. A reference accumulator using the emitted digits and `a_mul_*` matches (a·b) mod 2^13.
